// File: rtl/vpu_ovi_issue_buffer_if.sv
// OVI issue / dispatch / execute handshake bundle between the core side and the VPU issue buffer.
interface vpu_ovi_issue_buffer_if #(
  parameter int SB_W = 5
);
  logic [31:0]     issue_inst;
  logic [SB_W-1:0] issue_sb_id;
  logic [63:0]     issue_scalar_opnd;
  logic [39:0]     issue_vcsr;
  logic            issue_vcsr_lmulb2;
  logic            issue_valid;
  logic            issue_credit;

  logic [SB_W-1:0] dispatch_sb_id;
  logic            dispatch_next_senior;
  logic            dispatch_kill;

  logic            exe_valid;
  logic            exe_ready;
  logic [31:0]     exe_inst;
  logic [SB_W-1:0] exe_sb_id;
  logic [63:0]     exe_scalar_opnd;
  logic [39:0]     exe_vcsr;
  logic            exe_vcsr_lmulb2;

  modport master (
    output issue_inst, issue_sb_id, issue_scalar_opnd, issue_vcsr, issue_vcsr_lmulb2,
           issue_valid, dispatch_sb_id, dispatch_next_senior, dispatch_kill, exe_ready,
    input  issue_credit, exe_valid, exe_inst, exe_sb_id, exe_scalar_opnd, exe_vcsr,
           exe_vcsr_lmulb2
  );

  modport slave (
    input  issue_inst, issue_sb_id, issue_scalar_opnd, issue_vcsr, issue_vcsr_lmulb2,
           issue_valid, dispatch_sb_id, dispatch_next_senior, dispatch_kill, exe_ready,
    output issue_credit, exe_valid, exe_inst, exe_sb_id, exe_scalar_opnd, exe_vcsr,
           exe_vcsr_lmulb2
  );
endinterface

// File: rtl/vpu_ovi_issue_buffer.sv
// In-order OVI issue buffer: holds issued vector instructions, applies dispatch events
// in order, forwards senior entries to execute and drops killed ones.
//
// entry state | meaning
// E_EMPTY     | slot free
// E_PENDING   | issued, waiting for its dispatch event
// E_SENIOR    | dispatched, may be sent to execute
// E_KILLED    | dispatched as killed, dropped when it reaches the head
module vpu_ovi_issue_buffer #(
  parameter int DEPTH = 4,
  parameter int SB_W  = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  vpu_ovi_issue_buffer_if.slave      ovi,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [1:0]                 err
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {E_EMPTY, E_PENDING, E_SENIOR, E_KILLED} ent_t;

  ent_t            st       [DEPTH];
  logic [31:0]     inst_q   [DEPTH];
  logic [SB_W-1:0] sb_q     [DEPTH];
  logic [63:0]     opnd_q   [DEPTH];
  logic [39:0]     vcsr_q   [DEPTH];
  logic            lmulb2_q [DEPTH];

  logic [AW:0]   head, tail, disp;
  logic [AW-1:0] head_idx, tail_idx, disp_idx;
  logic          full, empty, pend_avail, pop, accept, dsp_ev, sb_mis, credit_q;
  logic [1:0]    err_q;

  assign head_idx   = head[AW-1:0];
  assign tail_idx   = tail[AW-1:0];
  assign disp_idx   = disp[AW-1:0];
  assign empty      = (head == tail);
  assign full       = (head[AW] != tail[AW]) && (head_idx == tail_idx);
  // Entries between the dispatch and tail pointers are exactly the PENDING ones.
  assign pend_avail = (disp != tail);
  assign pop        = ((st[head_idx] == E_SENIOR) && ovi.exe_ready) || (st[head_idx] == E_KILLED);
  assign accept     = ovi.issue_valid && (!full || pop);
  assign dsp_ev     = ovi.dispatch_next_senior || ovi.dispatch_kill;
  assign sb_mis     = pend_avail && (ovi.dispatch_sb_id != sb_q[disp_idx]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= E_EMPTY;
      head     <= '0;
      tail     <= '0;
      disp     <= '0;
      credit_q <= 1'b0;
      err_q    <= 2'b00;
    end else begin
      credit_q <= pop;
      if (dsp_ev && pend_avail) begin
        st[disp_idx] <= ovi.dispatch_kill ? E_KILLED : E_SENIOR;
        disp         <= disp + 1'b1;
      end
      if (dsp_ev && ((ovi.dispatch_next_senior && ovi.dispatch_kill) || !pend_avail || sb_mis))
        err_q[1] <= 1'b1;
      if (ovi.issue_valid && !accept) err_q[0] <= 1'b1;
      if (pop) begin
        st[head_idx] <= E_EMPTY;
        head         <= head + 1'b1;
      end
      // On a full buffer the popped head slot is the tail slot; the new entry overrides it.
      if (accept) begin
        st[tail_idx] <= E_PENDING;
        tail         <= tail + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      inst_q[tail_idx]   <= ovi.issue_inst;
      sb_q[tail_idx]     <= ovi.issue_sb_id;
      opnd_q[tail_idx]   <= ovi.issue_scalar_opnd;
      vcsr_q[tail_idx]   <= ovi.issue_vcsr;
      lmulb2_q[tail_idx] <= ovi.issue_vcsr_lmulb2;
    end
  end

  assign ovi.issue_credit    = credit_q;
  assign ovi.exe_valid       = (st[head_idx] == E_SENIOR);
  assign ovi.exe_inst        = empty ? '0 : inst_q[head_idx];
  assign ovi.exe_sb_id       = empty ? '0 : sb_q[head_idx];
  assign ovi.exe_scalar_opnd = empty ? '0 : opnd_q[head_idx];
  assign ovi.exe_vcsr        = empty ? '0 : vcsr_q[head_idx];
  assign ovi.exe_vcsr_lmulb2 = empty ? 1'b0 : lmulb2_q[head_idx];
  assign occupancy           = OW'(tail - head);
  assign err                 = err_q;
endmodule

// File: tb/tb_vpu_ovi_issue_buffer.sv
// Bench for vpu_ovi_issue_buffer: directed scenarios plus random traffic against a queue model.
module tb_vpu_ovi_issue_buffer;
  localparam int DEPTH = 4;
  localparam int SB_W  = 5;
  localparam int PW    = 32 + SB_W + 64 + 40 + 1;

  typedef enum {M_PEN, M_SEN, M_KIL} mst_t;
  typedef struct {
    logic [PW-1:0]   pkt;
    logic [SB_W-1:0] sb;
    mst_t            st;
  } ment_t;

  logic       clk;
  logic       reset_n;
  logic [2:0] occupancy;
  logic [1:0] err;

  vpu_ovi_issue_buffer_if #(.SB_W(SB_W)) ovi ();

  vpu_ovi_issue_buffer #(.DEPTH(DEPTH), .SB_W(SB_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ovi       (ovi),
    .occupancy (occupancy),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ment_t      q[$];
  logic [1:0] m_err;
  logic       m_credit;
  int         total = 0;
  int         bad = 0;
  int         credit_seen = 0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [PW-1:0] obs_pkt;
    logic [PW-1:0] exp_pkt;
    logic          exp_v;
    exp_v   = (q.size() > 0) && (q[0].st == M_SEN);
    exp_pkt = (q.size() > 0) ? q[0].pkt : '0;
    obs_pkt = {ovi.exe_inst, ovi.exe_sb_id, ovi.exe_scalar_opnd, ovi.exe_vcsr, ovi.exe_vcsr_lmulb2};
    chk("exe_valid", PW'(ovi.exe_valid), PW'(exp_v));
    chk("exe_fields", obs_pkt, exp_pkt);
    chk("occupancy", PW'(occupancy), PW'(q.size()));
    chk("err", PW'(err), PW'(m_err));
    chk("issue_credit", PW'(ovi.issue_credit), PW'(m_credit));
  endtask

  task automatic drive_idle();
    ovi.issue_valid          = 1'b0;
    ovi.issue_sb_id          = '0;
    ovi.issue_inst           = '0;
    ovi.issue_scalar_opnd    = '0;
    ovi.issue_vcsr           = '0;
    ovi.issue_vcsr_lmulb2    = 1'b0;
    ovi.dispatch_sb_id       = '0;
    ovi.dispatch_next_senior = 1'b0;
    ovi.dispatch_kill        = 1'b0;
    ovi.exe_ready            = 1'b0;
  endtask

  // One clock: drive inputs, advance the model by the same rules, then compare after the edge.
  task automatic step(input bit iv, input int sb, input bit ns, input bit kl, input int dsb,
                      input bit rdy);
    int    di;
    bit    pop;
    bit    acc;
    ment_t e;
    ovi.issue_valid          = iv;
    ovi.issue_sb_id          = SB_W'(sb);
    ovi.issue_inst           = $urandom;
    ovi.issue_scalar_opnd    = {$urandom, $urandom};
    ovi.issue_vcsr           = {8'($urandom), 32'($urandom)};
    ovi.issue_vcsr_lmulb2    = 1'($urandom);
    ovi.dispatch_sb_id       = SB_W'(dsb);
    ovi.dispatch_next_senior = ns;
    ovi.dispatch_kill        = kl;
    ovi.exe_ready            = rdy;

    di = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].st == M_PEN) begin
        di = i;
        break;
      end
    end
    pop = (q.size() > 0) && (((q[0].st == M_SEN) && rdy) || (q[0].st == M_KIL));
    acc = iv && ((q.size() < DEPTH) || pop);
    if (ns || kl) begin
      if (ns && kl) m_err[1] = 1'b1;
      if (di < 0) m_err[1] = 1'b1;
      else begin
        e = q[di];
        if (e.sb != SB_W'(dsb)) m_err[1] = 1'b1;
        e.st = kl ? M_KIL : M_SEN;
        q[di] = e;
      end
    end
    if (iv && !acc) m_err[0] = 1'b1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      e.pkt = {ovi.issue_inst, ovi.issue_sb_id, ovi.issue_scalar_opnd, ovi.issue_vcsr,
               ovi.issue_vcsr_lmulb2};
      e.sb  = ovi.issue_sb_id;
      e.st  = M_PEN;
      q.push_back(e);
    end
    m_credit = pop;

    @(posedge clk);
    #1;
    if (ovi.issue_credit) credit_seen++;
    check_outputs();
  endtask

  // Reset is applied mid-cycle so the clear is seen before any clock edge.
  task automatic apply_reset();
    drive_idle();
    reset_n = 1'b0;
    #2;
    q.delete();
    m_err    = 2'b00;
    m_credit = 1'b0;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    reset_n = 1'b1;
  endtask

  function automatic int first_pend_sb();
    for (int i = 0; i < q.size(); i++)
      if (q[i].st == M_PEN) return int'(q[i].sb);
    return int'($urandom_range(0, 31));
  endfunction

  int c0;
  int ns_r, kl_r, dsb_r;

  initial begin
    drive_idle();
    reset_n  = 1'b0;
    m_err    = 2'b00;
    m_credit = 1'b0;
    #1;
    apply_reset();

    // issue, senior next cycle, pop, credit
    step(1, 3, 0, 0, 0, 1);
    step(0, 0, 1, 0, 3, 1);
    chk("t1_exe_valid", PW'(ovi.exe_valid), PW'(1));
    chk("t1_sb_id", PW'(ovi.exe_sb_id), PW'(3));
    step(0, 0, 0, 0, 0, 1);
    chk("t1_credit", PW'(ovi.issue_credit), PW'(1));
    step(0, 0, 0, 0, 0, 1);

    // kill 1, senior 2
    apply_reset();
    c0 = credit_seen;
    step(1, 1, 0, 0, 0, 1);
    step(1, 2, 0, 1, 1, 1);
    step(0, 0, 1, 0, 2, 1);
    chk("t2_sb_id", PW'(ovi.exe_sb_id), PW'(2));
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t2_credits", PW'(credit_seen - c0), PW'(2));

    // overflow on a full, stalled buffer
    apply_reset();
    for (int k = 0; k < 4; k++) step(1, 10 + k, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 10 + k, 0);
    step(1, 20, 0, 0, 0, 0);
    chk("t3_err", PW'(err), PW'(2'b01));
    chk("t3_occ", PW'(occupancy), PW'(4));
    chk("t3_head_sb", PW'(ovi.exe_sb_id), PW'(10));

    // full buffer: pop and issue in the same cycle
    apply_reset();
    for (int k = 0; k < 4; k++) step(1, 10 + k, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 10 + k, 0);
    step(1, 21, 0, 0, 0, 1);
    chk("t4_err", PW'(err), PW'(2'b00));
    chk("t4_occ", PW'(occupancy), PW'(4));
    chk("t4_head_sb", PW'(ovi.exe_sb_id), PW'(11));

    // sb_id mismatch, then simultaneous senior+kill
    apply_reset();
    step(1, 7, 0, 0, 0, 0);
    step(0, 0, 1, 0, 6, 0);
    chk("t5_err_mis", PW'(err), PW'(2'b10));
    chk("t5_senior", PW'(ovi.exe_valid), PW'(1));
    apply_reset();
    step(1, 8, 0, 0, 0, 0);
    step(0, 0, 1, 1, 8, 0);
    chk("t5_err_both", PW'(err), PW'(2'b10));
    chk("t5_killed", PW'(ovi.exe_valid), PW'(0));
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);

    // reset with entries held, then wrap the pointers
    apply_reset();
    step(1, 4, 0, 0, 0, 0);
    step(1, 5, 1, 0, 9, 0);
    step(1, 6, 0, 0, 0, 0);
    chk("t6_pre_valid", PW'(ovi.exe_valid), PW'(1));
    apply_reset();
    chk("t6_occ", PW'(occupancy), PW'(0));
    c0 = credit_seen;
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1);
    chk("t6_no_credit", PW'(credit_seen - c0), PW'(0));
    step(1, 0, 0, 0, 0, 1);
    for (int k = 1; k < 10; k++) step(1, k, 1, 0, k - 1, 1);
    step(0, 0, 1, 0, 9, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t6_drained", PW'(occupancy), PW'(0));

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if (n % 80 == 0) apply_reset();
      ns_r  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      kl_r  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      dsb_r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : first_pend_sb();
      step(($urandom_range(0, 2) != 0), int'($urandom_range(0, 31)), ns_r[0], kl_r[0], dsb_r,
           ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
